ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage. Consumes operands and rd from the ID/EX
//  register outputs, stalls the front of the pipeline via OUT_BUSY while iterating, and presents
//  the result with a one-cycle OUT_DONE pulse for EX/MEM capture. Honours the PC_SEL flush used by
//  the pipeline registers.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN
// PORTS
//  CLK          in   1     clock, rising edge
//  RESET        in   1     asynchronous, active-high reset
//  PC_SEL       in   1     branch/jump taken flush: abort any in-flight op
//  IN_START     in   1     issue request, sampled only in IDLE
//  IN_MD_OP     in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  IN_DATA1     in   XLEN  rs1 value (dividend / multiplicand)
//  IN_DATA2     in   XLEN  rs2 value (divisor / multiplier)
//  IN_RD        in   5     destination register index
//  OUT_BUSY     out  1     stall request to PC/IF-ID/ID-EX; high in MUL/DIV states
//  OUT_DONE     out  1     one-cycle result-valid pulse
//  OUT_RESULT   out  XLEN  result; valid only when OUT_DONE=1
//  OUT_RD       out  5     rd of the op; valid only when OUT_DONE=1
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, OUT_BUSY=0, OUT_DONE=0, OUT_RESULT=0, OUT_RD=0, counter=0.
//  - States: IDLE, MUL, DIV, DONE. Accept cycle N = IDLE & IN_START & !PC_SEL; latch op, operands, rd.
//  - IDLE -> MUL (op[2]=0) or DIV (op[2]=1) at edge N. MUL/DIV run XLEN iterations (counter 0..XLEN-1),
//    then -> DONE; DONE -> IDLE after one cycle. OUT_DONE=1 only in DONE, i.e. cycle N+XLEN+1.
//  - OUT_BUSY=1 in MUL and DIV only; 0 in IDLE and DONE. IN_START outside IDLE is ignored.
//  - MUL: radix-2 shift-add on |operands| in a 2*XLEN product; sign fixup at end per op.
//    MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits (signed*signed, signed*unsigned, unsigned).
//  - DIV: restoring, one quotient bit per cycle on magnitudes; quotient negated if signs differ,
//    remainder takes dividend sign.
//  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend. No trap.
//  - Signed overflow (0x8000_0000 / -1): DIV -> 0x8000_0000; REM -> 0.
//  - PC_SEL=1 in MUL/DIV: next state IDLE, OUT_BUSY drops next cycle, no OUT_DONE, result discarded.
//    PC_SEL=1 in DONE: OUT_DONE still pulses (op is older than the branch). PC_SEL with IN_START in IDLE: no accept.
//  - OUT_RESULT/OUT_RD hold last value outside DONE; only written on entry to DONE.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: at accept, MUL* with either operand 0, divide by zero and signed
//    overflow go IDLE -> DONE directly (OUT_DONE at N+1, OUT_BUSY never asserted) with the results above.
//  Not defined: every op takes the full XLEN iterations (OUT_DONE at N+XLEN+1); results identical.
// TESTING
//  1 MUL 7 x -3 -> OUT_DONE at N+33, OUT_RESULT=0xFFFF_FFEB, OUT_RD=issued rd, OUT_BUSY high N+1..N+32.
//  2 MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULH same operands -> 0x0000_0000.
//  3 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIV 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0;
//    latency N+1 with MULDIV_EARLY_OUT_EN, N+33 without.
//  5 PC_SEL pulse at N+10 of a DIV -> OUT_BUSY=0 at N+11, no OUT_DONE; next IN_START accepted normally.
//  6 RESET asserted at N+5 mid-MUL (async, between edges) -> all outputs 0 immediately; IN_START while busy ignored.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Ports:
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   PC_SEL          branch/jump flush; aborts an op still iterating
//   IN_START        issue request, sampled only while idle
//   IN_MD_OP        funct3 (MUL MULH MULHSU MULHU DIV DIVU REM REMU)
//   IN_DATA1/2      rs1 / rs2 operand values
//   IN_RD           destination register index
//   OUT_BUSY        stall request while iterating
//   OUT_DONE        one-cycle result-valid pulse
//   OUT_RESULT      result, valid with OUT_DONE
//   OUT_RD          rd of the completed op, valid with OUT_DONE
//
// Build option: MULDIV_EARLY_OUT_EN retires trivial ops (zero multiply
// operand, divide by zero, signed overflow) one cycle after accept.

module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            PC_SEL,
    input  logic            IN_START,
    input  logic [2:0]      IN_MD_OP,
    input  logic [XLEN-1:0] IN_DATA1,
    input  logic [XLEN-1:0] IN_DATA2,
    input  logic [4:0]      IN_RD,
    output logic            OUT_BUSY,
    output logic            OUT_DONE,
    output logic [XLEN-1:0] OUT_RESULT,
    output logic [4:0]      OUT_RD
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   d1_q;
    logic [XLEN-1:0]   d2_q;
    logic [XLEN-1:0]   mag_b;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic              neg_q;      // product / quotient sign
    logic              negr_q;     // remainder sign (dividend sign)

    // Operand signedness from funct3: rs1 is signed for MUL/MULH/MULHSU/DIV/REM,
    // rs2 for MUL/MULH/DIV/REM.
    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        sgn1 = IN_MD_OP[2] ? !IN_MD_OP[0] : (IN_MD_OP[1:0] != 2'b11);
        sgn2 = IN_MD_OP[2] ? !IN_MD_OP[0] : !IN_MD_OP[1];
        neg1 = sgn1 & IN_DATA1[XLEN-1];
        neg2 = sgn2 & IN_DATA2[XLEN-1];
        mag1 = neg1 ? -IN_DATA1 : IN_DATA1;
        mag2 = neg2 ? -IN_DATA2 : IN_DATA2;
    end

    // One iteration step for each engine.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, mag_b};
        // A borrow out means the divisor did not fit: restore and shift in 0.
        div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Final result is formed from the last iteration's next value so it can be
    // registered on the same edge that enters DONE.
    logic [2*XLEN-1:0] acc_fin;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        acc_fin  = (state == S_DIV) ? div_next : mul_next;
        prod_fix = neg_q ? -acc_fin : acc_fin;
        quo_fix  = neg_q  ? -acc_fin[XLEN-1:0]      : acc_fin[XLEN-1:0];
        rem_fix  = negr_q ? -acc_fin[2*XLEN-1:XLEN] : acc_fin[2*XLEN-1:XLEN];
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (d2_q == '0) begin
            final_res = op_q[1] ? d1_q : '1;
        end else begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (!IN_MD_OP[2]) begin
            early_hit = (IN_DATA1 == '0) || (IN_DATA2 == '0);
        end else if (IN_DATA2 == '0) begin
            early_hit = 1'b1;
            early_res = IN_MD_OP[1] ? IN_DATA1 : '1;
        end else if (!IN_MD_OP[0] && (IN_DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (IN_DATA2 == '1)) begin
            early_hit = 1'b1;
            early_res = IN_MD_OP[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            mag_b      <= '0;
            acc        <= '0;
            neg_q      <= 1'b0;
            negr_q     <= 1'b0;
            OUT_RESULT <= '0;
            OUT_RD     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_START && !PC_SEL) begin
                        op_q   <= IN_MD_OP;
                        rd_q   <= IN_RD;
                        d1_q   <= IN_DATA1;
                        d2_q   <= IN_DATA2;
                        neg_q  <= neg1 ^ neg2;
                        negr_q <= neg1;
                        cnt    <= '0;
                        mag_b  <= IN_MD_OP[2] ? mag2 : mag1;
                        acc    <= {{XLEN{1'b0}}, (IN_MD_OP[2] ? mag1 : mag2)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            OUT_RESULT <= early_res;
                            OUT_RD     <= IN_RD;
                            state      <= S_DONE;
                        end else begin
                            state <= IN_MD_OP[2] ? S_DIV : S_MUL;
                        end
`else
                        state <= IN_MD_OP[2] ? S_DIV : S_MUL;
`endif
                    end
                end
                S_MUL, S_DIV: begin
                    if (PC_SEL) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_fin;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN-1)) begin
                            OUT_RESULT <= final_res;
                            OUT_RD     <= rd_q;
                            state      <= S_DONE;
                        end
                    end
                end
                default: begin
                    // DONE: the op predates any flush, so it always retires.
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_BUSY = (state == S_MUL) || (state == S_DIV);
    assign OUT_DONE = (state == S_DONE);

endmodule
